izhikevich_scheduler: RTL
=========================

Name: izhikevich_scheduler

Overview:
Time-multiplexes one Izhikevich update datapath across NUM_NEURONS neurons held in internal state registers. On each start pulse it performs one Euler timestep for every neuron in index order: compute dv/dw, update v/w, detect spikes, apply the after-spike reset, and emit spike events over a valid/ready port. Sits between the network-level timestep sequencer and the synapse/event router.

Parameters:
N, 32, fixed-point word width (signed two's complement)
Q, 16, fractional bits (Q16.16)
NUM_NEURONS, 8, neurons serviced per timestep
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_NEURONS

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one timestep; sampled only in IDLE
step  in  N  Euler step dt, Q16.16
a  in  N  recovery rate, Q16.16
b  in  N  recovery sensitivity, Q16.16
c  in  N  post-spike v reset value, Q16.16
d  in  N  post-spike w increment, Q16.16
i_wr_en  in  1  write input current register
i_wr_idx  in  IDX_W  neuron index for current write
i_wr_data  in  N  input current, Q16.16
busy  out  1  high while timestep in progress
done  out  1  one-cycle pulse when timestep completes
spike_valid  out  1  spike event available
spike_ready  in  1  consumer accepts spike event
spike_idx  out  IDX_W  index of spiking neuron

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low, on rst_n.
- Reset: FSM=IDLE; busy=0, done=0, spike_valid=0, spike_idx=0; index=0; every v=-65.0 (0xFFBF0000), w=-13.0 (0xFFF30000), i=0.
- Arithmetic: Q16.16 signed; multiply keeps product bits [N+Q-1:Q], truncating, no saturation; add wraps. Matches the existing calc_dv datapath.
- dv = (0.04v^2 + 5v + 140 - w + i)*step, via calc_dv.
- dw = a*(b*v - w)*step, via calc_dw.
- v_new = v + dv; w_new = w + dw.
- Spike: signed v_new >= 30.0 (0x001E0000). On spike, store v=c and w=w_new+d; otherwise store v_new and w_new.
- FSM states:
  - IDLE: start=1 -> LOAD with index=0; busy rises the next cycle.
  - LOAD: register v[idx], w[idx], i[idx] into operand regs -> COMPUTE.
  - COMPUTE: register dv, dw and the spike flag -> WRITE.
  - WRITE: write back v/w. If spike -> EMIT; else if idx==NUM_NEURONS-1 -> FINISH; else idx++ -> LOAD.
  - EMIT: spike_valid=1, spike_idx=idx. Hold until spike_valid&&spike_ready, then advance as WRITE does.
  - FINISH: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
- Latency: 3 cycles per non-spiking neuron; spiking neuron 3 + (cycles until ready) + 1. With start accepted at cycle t and no spikes, busy is high for cycles t+1..t+3*NUM_NEURONS and done pulses at t+3*NUM_NEURONS+1.
- start while busy, or in FINISH: ignored, not queued.
- Current writes: allowed at any time. A write to the index in LOAD in the same cycle is not seen this timestep (old value used). Out-of-range idx is ignored.
- spike_valid, once asserted, is held with a stable spike_idx until accepted.
- a/b/c/d/step must be held stable while busy; they are sampled combinationally in COMPUTE/WRITE.
- rst_n low mid-timestep: immediate return to the reset state; any pending spike is dropped.

Decomposition:
- Package izh_pkg:
  - typedef fixed_t (logic signed [N-1:0])
  - FSM state enum
  - constants V_INIT, W_INIT, V_PEAK, C_0P04 (0x00000A3D), C_5, C_140
- Sub-module calc_dw: combinational, ports v, w, a, b, step -> out, built from the shared mult/add/negator cells.
- calc_dv is instantiated unchanged.

Test Plan:
- Reset: rst_n low then high -> busy=0, done=0, spike_valid=0. Single start with i=0, step=1.0 and a/b/c/d=0.02/0.2/-65/8 -> neuron 0 v ≈ -68.0 (±0x100 LSB), no spikes.
- Timing: NUM_NEURONS=8, no spikes, start at cycle t -> done pulses exactly at t+25; busy high for cycles t+1..t+24.
- Spike: i[3]=1000.0, step=1.0, spike_ready=1 -> one event with spike_idx=3. Afterwards v[3]=c=0xFFBF0000 and w[3] ≈ -5.0 (0xFFFB0000 ±0x10 LSB); done arrives at t+26.
- Backpressure: same spike with spike_ready held low 5 cycles -> spike_valid stays high, spike_idx=3 stable, FSM frozen; done delayed by 5 cycles.
- start while busy: pulse start mid-timestep -> ignored; exactly one done pulse.
- Reset mid-operation: rst_n low during EMIT -> spike_valid drops immediately; v/w return to -65.0/-13.0; the next start runs normally.

Source files
------------

// File: rtl/izh_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : izh_pkg                                                          |
// | Shared Q16.16 types, scheduler FSM encoding and the fixed Izhikevich       |
// | model constants used by the scheduler and its arithmetic datapaths.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package izh_pkg;

  localparam int FX_N = 32;  // word width
  localparam int FX_Q = 16;  // fractional bits

  typedef logic signed [FX_N-1:0] fixed_t;

  // Scheduler states, explicitly 3 bits wide with fixed encodings.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_EMIT    = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam fixed_t V_INIT = 32'hFFBF_0000;  // -65.0
  localparam fixed_t W_INIT = 32'hFFF3_0000;  // -13.0
  localparam fixed_t V_PEAK = 32'h001E_0000;  //  30.0
  localparam fixed_t C_0P04 = 32'h0000_0A3D;  //   0.04
  localparam fixed_t C_5    = 32'h0005_0000;  //   5.0
  localparam fixed_t C_140  = 32'h008C_0000;  // 140.0

endpackage : izh_pkg
`default_nettype wire

// File: rtl/calc_dv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : calc_dv                                                          |
// | Combinational membrane derivative:                                         |
// |   out = (0.04*v*v + 5*v + 140 - w + i) * step                              |
// | v*v is formed first, then scaled by 0.04.                                  |
// | Ports   : v, w, i, step (Q16.16) -> out (Q16.16)                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module calc_dv
  import izh_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] i,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] out
);

  logic signed [N-1:0] vv, sq_term, lin_term, s0, s1, neg_w, s2, s3;

  izh_mul #(.N(N), .Q(Q)) u_mul_vv  (.x(v),      .y(v),     .p(vv));
  izh_mul #(.N(N), .Q(Q)) u_mul_sq  (.x(C_0P04), .y(vv),    .p(sq_term));
  izh_mul #(.N(N), .Q(Q)) u_mul_lin (.x(C_5),    .y(v),     .p(lin_term));
  izh_add #(.N(N))        u_add_0   (.x(sq_term), .y(lin_term), .p(s0));
  izh_add #(.N(N))        u_add_1   (.x(s0),     .y(C_140), .p(s1));
  izh_neg #(.N(N))        u_neg_w   (.x(w),      .p(neg_w));
  izh_add #(.N(N))        u_add_2   (.x(s1),     .y(neg_w), .p(s2));
  izh_add #(.N(N))        u_add_3   (.x(s2),     .y(i),     .p(s3));
  izh_mul #(.N(N), .Q(Q)) u_mul_dt  (.x(s3),     .y(step),  .p(out));

endmodule : calc_dv
`default_nettype wire

// File: rtl/calc_dw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : calc_dw                                                          |
// | Combinational recovery derivative:                                         |
// |   out = (a * (b*v - w)) * step                                             |
// | Ports   : v, w, a, b, step (Q16.16) -> out (Q16.16)                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module calc_dw #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] out
);

  logic signed [N-1:0] bv, neg_w, diff, scaled;

  izh_mul #(.N(N), .Q(Q)) u_mul_bv (.x(b),      .y(v),     .p(bv));
  izh_neg #(.N(N))        u_neg_w  (.x(w),      .p(neg_w));
  izh_add #(.N(N))        u_add    (.x(bv),     .y(neg_w), .p(diff));
  izh_mul #(.N(N), .Q(Q)) u_mul_a  (.x(a),      .y(diff),  .p(scaled));
  izh_mul #(.N(N), .Q(Q)) u_mul_dt (.x(scaled), .y(step),  .p(out));

endmodule : calc_dw
`default_nettype wire

// File: rtl/izh_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : izh_add                                                          |
// | Wrapping two's complement adder cell.                                      |
// | Ports   : x, y (operands) -> p (sum)                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module izh_add #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] y,
  output logic signed [N-1:0] p
);

  assign p = x + y;

endmodule : izh_add
`default_nettype wire

// File: rtl/izh_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : izh_mul                                                          |
// | Signed fixed-point multiplier cell. Keeps product bits [N+Q-1:Q]:          |
// | truncating toward minus infinity, wrapping on overflow, no saturation.     |
// | Ports   : x, y (operands) -> p (product)                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module izh_mul #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] y,
  output logic signed [N-1:0] p
);

  logic signed [2*N-1:0] full;

  assign full = (2*N)'(x) * (2*N)'(y);
  assign p    = N'(full >>> Q);

endmodule : izh_mul
`default_nettype wire

// File: rtl/izh_neg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : izh_neg                                                          |
// | Two's complement negator cell (wraps for the most negative value).         |
// | Ports   : x -> p (= -x)                                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module izh_neg #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] x,
  output logic signed [N-1:0] p
);

  assign p = -x;

endmodule : izh_neg
`default_nettype wire

// File: rtl/izhikevich_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : izhikevich_scheduler                                             |
// | Time-multiplexes one Izhikevich Euler-update datapath across NUM_NEURONS   |
// | neurons. Each start pulse updates every neuron in index order and emits   |
// | one spike event (valid/ready) per neuron crossing the peak.                |
// | Ports   : clk, rst_n           clock, async active-low reset               |
// |           start                begin a timestep (honoured only in IDLE)    |
// |           step,a,b,c,d         model parameters, stable while busy         |
// |           i_wr_en/idx/data     input-current register write port           |
// |           busy, done           timestep in progress / completion pulse     |
// |           spike_valid/ready/idx spike event handshake                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module izhikevich_scheduler
  import izh_pkg::*;
#(
  parameter int N           = 32,
  parameter int Q           = 16,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     step,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [N-1:0]     i_wr_data,
  output logic             busy,
  output logic             done,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [IDX_W-1:0] spike_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_NEURONS);

  state_e                state;
  logic [IDX_W-1:0]      idx;

  logic signed [N-1:0]   v_mem [NUM_NEURONS];
  logic signed [N-1:0]   w_mem [NUM_NEURONS];
  logic signed [N-1:0]   i_mem [NUM_NEURONS];

  logic signed [N-1:0]   v_op, w_op, i_op;
  logic signed [N-1:0]   dv_q, dw_q;
  logic                  spike_q;

  logic signed [N-1:0]   dv_w, dw_w;
  logic signed [N-1:0]   v_cand, v_new, w_new;
  logic                  wr_in_range;

  calc_dv #(.N(N), .Q(Q)) u_calc_dv (
    .v    (v_op),
    .w    (w_op),
    .i    (i_op),
    .step (step),
    .out  (dv_w)
  );

  calc_dw #(.N(N), .Q(Q)) u_calc_dw (
    .v    (v_op),
    .w    (w_op),
    .a    (a),
    .b    (b),
    .step (step),
    .out  (dw_w)
  );

  // The spike decision is made from the COMPUTE-cycle sum; WRITE recomputes
  // the same sum from the registered derivatives for the write-back.
  assign v_cand = v_op + dv_w;
  assign v_new  = v_op + dv_q;
  assign w_new  = w_op + dw_q;

  // Widened compare so the range test stays meaningful when NUM_NEURONS
  // fills the whole index space.
  assign wr_in_range = ({1'b0, i_wr_idx} < NUM_EXT);

  assign busy        = (state == ST_LOAD) || (state == ST_COMPUTE) ||
                       (state == ST_WRITE) || (state == ST_EMIT);
  assign done        = (state == ST_FINISH);
  assign spike_valid = (state == ST_EMIT);
  assign spike_idx   = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      v_op    <= '0;
      w_op    <= '0;
      i_op    <= '0;
      dv_q    <= '0;
      dw_q    <= '0;
      spike_q <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        w_mem[k] <= W_INIT;
        i_mem[k] <= '0;
      end
    end else begin
      // Current writes are independent of the FSM; a write landing during
      // LOAD of the same neuron is not seen until the next timestep because
      // the operand register samples the pre-write value.
      if (i_wr_en && wr_in_range) begin
        i_mem[i_wr_idx] <= i_wr_data;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          v_op  <= v_mem[idx];
          w_op  <= w_mem[idx];
          i_op  <= i_mem[idx];
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          dv_q    <= dv_w;
          dw_q    <= dw_w;
          spike_q <= (v_cand >= V_PEAK);
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (spike_q) begin
            v_mem[idx] <= c;
            w_mem[idx] <= w_new + $signed(d);
            state      <= ST_EMIT;
          end else begin
            v_mem[idx] <= v_new;
            w_mem[idx] <= w_new;
            if (idx == LAST_IDX) begin
              state <= ST_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_EMIT: begin
          // Event is held with a stable index until the consumer takes it.
          if (spike_ready) begin
            if (idx == LAST_IDX) begin
              state <= ST_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : izhikevich_scheduler
`default_nettype wire
